table_fsm: RTL and testbench
============================

TABLE_FSM -- requirements
Module: table_fsm

Interface
REQ-001 SHALL have parameter STATE_W, default 2: state code width.
REQ-002 SHALL have parameter NUM_STATES, default 4: legal states 0..NUM_STATES-1, with NUM_STATES <= 2**STATE_W.
REQ-003 SHALL have parameter IN_W, default 2: input symbol width.
REQ-004 SHALL have parameter OUT_W, default 1: output word width.
REQ-005 SHALL have parameter RESET_STATE, default 0: state entered on reset or restart.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port restart, input, 1: synchronous return to RESET_STATE.
REQ-009 SHALL have port in_valid, input, 1: qualifies input_signal.
REQ-010 SHALL have port input_signal, input, IN_W: input symbol.
REQ-011 SHALL have port out_valid, output, 1: output_signal is valid.
REQ-012 SHALL have port output_signal, output, OUT_W: registered Mealy output.
REQ-013 SHALL have port current_state, output, STATE_W: present state.
REQ-014 SHALL have port err_illegal, output, 1: sticky illegal-state flag.
REQ-015 SHALL have port cfg_we, input, 1: table write strobe.
REQ-016 SHALL have port cfg_addr, input, STATE_W+IN_W: table index {state, symbol}.
REQ-017 SHALL have port cfg_data, input, STATE_W+OUT_W: table entry {next_state, out}.
REQ-018 SHALL have port dwell_cnt, output, 16: cycles spent in current state.

Function
REQ-019 SHALL hold a table of 2**(STATE_W+IN_W) entries, looked up at index {current_state, input_signal}.
REQ-020 SHALL, on a cycle with in_valid=1, load the entry's next_state into current_state and the entry's out into output_signal on that edge, and set out_valid=1 for exactly the following cycle (latency 1).
REQ-021 SHALL, on a cycle with in_valid=0, hold current_state and output_signal, with out_valid=0.
REQ-022 SHALL write cfg_data into the table at cfg_addr on a clock edge where cfg_we=1.
REQ-023 SHALL use the old entry for a lookup when a write hits the same entry in the same cycle; the new entry applies from the next cycle.
REQ-024 SHALL, if a lookup returns next_state >= NUM_STATES, enter RESET_STATE instead, set err_illegal, and still emit the entry's out with out_valid=1.
REQ-025 SHALL treat restart=1 as taking priority over in_valid: current_state goes to RESET_STATE, out_valid=0, output_signal is held, err_illegal is cleared, and dwell_cnt goes to 0.
REQ-026 SHALL reset dwell_cnt to 0 on any edge that changes current_state, and otherwise increment it, saturating at 16'hFFFF.

Reset
REQ-027 SHALL, while reset is asserted, set current_state=RESET_STATE, output_signal=0, out_valid=0, err_illegal=0 and dwell_cnt=0, independent of clk.
REQ-028 SHALL, on reset, initialise every table entry to {next_state = that entry's own state index, out=0}, i.e. self-loop with zero output.
REQ-029 SHALL ignore a cfg_we that coincides with reset.

Configuration
REQ-030 SHALL, when FSM_TBL_DWELL_EN is defined, implement dwell_cnt per REQ-026.
REQ-031 SHALL, when FSM_TBL_DWELL_EN is undefined, keep the dwell_cnt port present, tie it to 0, and instantiate no counter.

Structure
REQ-032 SHALL place the entry field offsets and widths, and the index-pack/unpack functions, in the shared package table_fsm_pkg.
REQ-033 SHALL implement the table as the sub-module table_fsm_tbl (a register file with async reset, one write port and one combinational read port).

Verification
REQ-034 SHALL cover: defaults, reset, no writes, in_valid=1 with input=2'b10 -> one cycle later out_valid=1, output_signal=0, current_state=0.
REQ-035 SHALL cover: load the 4-state table {S0: in->S(in), out=1}, then drive inputs 01,11 -> states 1 then 3, outputs as programmed, each with latency 1.
REQ-036 SHALL cover: write entry {state=2, symbol=0} while driving that same lookup in the same cycle -> the old result; the next lookup gets the new result.
REQ-037 SHALL cover: NUM_STATES=3, entry with next_state=3 -> current_state=0, err_illegal=1 stays set until restart.
REQ-038 SHALL cover: restart and in_valid together -> state=RESET_STATE, out_valid=0; async reset mid-stream -> all outputs 0 before the next edge.
REQ-039 SHALL cover: with FSM_TBL_DWELL_EN, idle for 70000 cycles -> dwell_cnt=16'hFFFF; a state change -> 0; without the macro -> always 0.

Source files
------------

// File: rtl/table_fsm_pkg.sv
// table_fsm_pkg -- shared definitions for the table-driven FSM.
//   Table entry layout : {next_state, out}; out at bit ENT_OUT_LSB,
//                        next_state at bit ent_ns_lsb(OUT_W).
//   Table index layout : {state, symbol}.
//   step_e classifies what a cycle does to the state register.
package table_fsm_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STEP    = 2'd1,
    ST_ILLEGAL = 2'd2,
    ST_RESTART = 2'd3
  } step_e;

  localparam int unsigned ENT_OUT_LSB = 0;

  function automatic int unsigned ent_ns_lsb(input int unsigned out_w);
    return out_w;
  endfunction

  function automatic int unsigned ent_width(input int unsigned state_w, input int unsigned out_w);
    return state_w + out_w;
  endfunction

  function automatic int unsigned idx_width(input int unsigned state_w, input int unsigned in_w);
    return state_w + in_w;
  endfunction

  function automatic int unsigned pack_idx(input int unsigned state, input int unsigned sym,
                                           input int unsigned in_w);
    return (state << in_w) | sym;
  endfunction

  function automatic int unsigned idx_state(input int unsigned idx, input int unsigned in_w);
    return idx >> in_w;
  endfunction

  function automatic int unsigned pack_ent(input int unsigned ns, input int unsigned out,
                                           input int unsigned out_w);
    return (ns << ent_ns_lsb(out_w)) | (out << ENT_OUT_LSB);
  endfunction

  function automatic int unsigned ent_ns(input int unsigned ent, input int unsigned out_w);
    return ent >> ent_ns_lsb(out_w);
  endfunction

  function automatic int unsigned ent_out(input int unsigned ent, input int unsigned out_w);
    return (ent >> ENT_OUT_LSB) & ((32'd1 << out_w) - 32'd1);
  endfunction

endpackage

// File: rtl/table_fsm_tbl.sv
// table_fsm_tbl -- transition table register file.
//   clk, reset : clock, async active-high reset (entries -> self-loop, out=0)
//   we, wr_addr, wr_data : single write port
//   rd_addr, rd_data     : combinational read port (sees pre-write contents)
module table_fsm_tbl
  import table_fsm_pkg::*;
#(
  parameter int unsigned STATE_W = 2,
  parameter int unsigned IN_W    = 2,
  parameter int unsigned OUT_W   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [STATE_W+IN_W-1:0]    wr_addr,
  input  logic [STATE_W+OUT_W-1:0]   wr_data,
  input  logic [STATE_W+IN_W-1:0]    rd_addr,
  output logic [STATE_W+OUT_W-1:0]   rd_data
);

  localparam int unsigned DW    = ent_width(STATE_W, OUT_W);
  localparam int unsigned DEPTH = 32'd1 << idx_width(STATE_W, IN_W);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= DW'(pack_ent(idx_state(i, IN_W), 0, OUT_W));
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/table_fsm.sv
// table_fsm -- table-driven Mealy FSM with registered output.
//   clk, reset        : clock, async active-high reset
//   restart           : sync return to RESET_STATE (beats in_valid)
//   in_valid, input_signal     : input symbol
//   out_valid, output_signal   : registered output, valid one cycle after input
//   current_state, err_illegal : present state, sticky illegal-next-state flag
//   cfg_we, cfg_addr, cfg_data : table write port, addr {state,symbol}, data {next,out}
//   dwell_cnt         : cycles in current state (FSM_TBL_DWELL_EN), else tied 0
module table_fsm
  import table_fsm_pkg::*;
#(
  parameter int unsigned STATE_W     = 2,
  parameter int unsigned NUM_STATES  = 4,
  parameter int unsigned IN_W        = 2,
  parameter int unsigned OUT_W       = 1,
  parameter int unsigned RESET_STATE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       restart,
  input  logic                       in_valid,
  input  logic [IN_W-1:0]            input_signal,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           output_signal,
  output logic [STATE_W-1:0]         current_state,
  output logic                       err_illegal,
  input  logic                       cfg_we,
  input  logic [STATE_W+IN_W-1:0]    cfg_addr,
  input  logic [STATE_W+OUT_W-1:0]   cfg_data,
  output logic [15:0]                dwell_cnt
);

  localparam int unsigned AW = idx_width(STATE_W, IN_W);
  localparam int unsigned DW = ent_width(STATE_W, OUT_W);
  localparam logic [STATE_W-1:0] RST_S = STATE_W'(RESET_STATE);

  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_ent;
  logic [STATE_W-1:0] lk_ns;
  logic [OUT_W-1:0]   lk_out;
  logic [STATE_W-1:0] state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               ov_q, ov_d;
  logic               err_q, err_d;
  step_e              step;

  table_fsm_tbl #(
    .STATE_W (STATE_W),
    .IN_W    (IN_W),
    .OUT_W   (OUT_W)
  ) u_tbl (
    .clk     (clk),
    .reset   (reset),
    .we      (cfg_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (rd_addr),
    .rd_data (rd_ent)
  );

  assign rd_addr = AW'(pack_idx(32'(state_q), 32'(input_signal), IN_W));
  assign lk_ns   = STATE_W'(ent_ns(32'(rd_ent), OUT_W));
  assign lk_out  = OUT_W'(ent_out(32'(rd_ent), OUT_W));

  always_comb begin
    step = ST_HOLD;
    if (restart) begin
      step = ST_RESTART;
    end else if (in_valid) begin
      step = (32'(lk_ns) >= NUM_STATES) ? ST_ILLEGAL : ST_STEP;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    err_d   = err_q;
    case (step)
      ST_RESTART: begin
        state_d = RST_S;
        err_d   = 1'b0;
      end
      ST_STEP: begin
        state_d = lk_ns;
        out_d   = lk_out;
        ov_d    = 1'b1;
      end
      ST_ILLEGAL: begin
        state_d = RST_S;
        out_d   = lk_out;
        ov_d    = 1'b1;
        err_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_S;
      out_q   <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

  assign current_state = state_q;
  assign output_signal = out_q;
  assign out_valid     = ov_q;
  assign err_illegal   = err_q;

`ifdef FSM_TBL_DWELL_EN
  logic [15:0] dwell_q;

  // Restart clears even when already in RESET_STATE (no state change).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q <= '0;
    end else if (step == ST_RESTART || state_d != state_q) begin
      dwell_q <= '0;
    end else if (dwell_q != '1) begin
      dwell_q <= dwell_q + 16'd1;
    end
  end

  assign dwell_cnt = dwell_q;
`else
  assign dwell_cnt = '0;
`endif

endmodule

// File: tb/tb_table_fsm.sv
module tb_table_fsm;

  logic        clk = 1'b0;
  logic        reset, restart0, restart1, iv0, iv1, cfg_we;
  logic [1:0]  input_signal;
  logic [3:0]  cfg_addr;
  logic [2:0]  cfg_data;
  logic        ov0, ov1, err0, err1;
  logic [0:0]  out0, out1;
  logic [1:0]  st0, st1;
  logic [15:0] dw0, dw1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0]  q0[$];
  logic [3:0]  q1[$];

`ifdef FSM_TBL_DWELL_EN
  localparam bit DWELL = 1'b1;
`else
  localparam bit DWELL = 1'b0;
`endif

  always #5 clk = ~clk;

  table_fsm #(
    .STATE_W(2), .NUM_STATES(4), .IN_W(2), .OUT_W(1), .RESET_STATE(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .restart(restart0), .in_valid(iv0),
    .input_signal(input_signal), .out_valid(ov0), .output_signal(out0),
    .current_state(st0), .err_illegal(err0), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .dwell_cnt(dw0)
  );

  table_fsm #(
    .STATE_W(2), .NUM_STATES(3), .IN_W(2), .OUT_W(1), .RESET_STATE(0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .restart(restart1), .in_valid(iv1),
    .input_signal(input_signal), .out_valid(ov1), .output_signal(out1),
    .current_state(st1), .err_illegal(err1), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .dwell_cnt(dw1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ex(input logic o, input logic [1:0] s, input logic e);
    return {o, s, e};
  endfunction

  // Monitor: every presented output is matched against the scoreboard.
  always @(negedge clk) begin
    if (ov0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_valid: got out_valid=1 expected no output");
      end else begin
        chk("dut0_output", 32'({out0, st0, err0}), 32'(q0.pop_front()));
      end
    end
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_valid: got out_valid=1 expected no output");
      end else begin
        chk("dut1_output", 32'({out1, st1, err1}), 32'(q1.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [2:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic in0(input logic [1:0] sym, input logic [3:0] exp);
    iv0 = 1'b1; input_signal = sym; q0.push_back(exp);
    step();
    iv0 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; restart0 = 1'b0; restart1 = 1'b0; iv0 = 1'b0; iv1 = 1'b0;
    input_signal = 2'b00;
    // write attempted during reset must be dropped: {0,10} -> {3,1}
    cfg_we = 1'b1; cfg_addr = 4'b0010; cfg_data = 3'b111;
    #1;
    chk("reset_state", 32'(st0), 32'd0);
    chk("reset_out", 32'(out0), 32'd0);
    chk("reset_valid", 32'(ov0), 32'd0);
    chk("reset_err", 32'(err0), 32'd0);
    chk("reset_dwell", 32'(dw0), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    cfg_we = 1'b0;
    reset = 1'b0;

    // default self-loop table, input 10 from S0
    in0(2'b10, ex(1'b0, 2'd0, 1'b0));
    step();

    // table: every state, symbol i -> S(i), out=1
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 4; i++)
        wr(4'(s * 4 + i), {2'(i), 1'b1});
    iv0 = 1'b1; input_signal = 2'b01; q0.push_back(ex(1'b1, 2'd1, 1'b0));
    step();
    input_signal = 2'b11; q0.push_back(ex(1'b1, 2'd3, 1'b0));
    step();
    iv0 = 1'b0;
    repeat (2) step();
    chk("hold_state", 32'(st0), 32'd3);
    chk("hold_out", 32'(out0), 32'd1);
    chk("hold_valid", 32'(ov0), 32'd0);

    // same-cycle write/lookup of entry {2,00}
    iv0 = 1'b1; input_signal = 2'b10; q0.push_back(ex(1'b1, 2'd2, 1'b0));
    step();
    cfg_we = 1'b1; cfg_addr = 4'b1000; cfg_data = 3'b010;
    input_signal = 2'b00; q0.push_back(ex(1'b1, 2'd0, 1'b0));
    step();
    cfg_we = 1'b0;
    input_signal = 2'b10; q0.push_back(ex(1'b1, 2'd2, 1'b0));
    step();
    input_signal = 2'b00; q0.push_back(ex(1'b0, 2'd1, 1'b0));
    step();
    input_signal = 2'b11; q0.push_back(ex(1'b1, 2'd3, 1'b0));
    step();
    iv0 = 1'b0;
    step();

    // restart beats in_valid; output held
    restart0 = 1'b1; iv0 = 1'b1; input_signal = 2'b01;
    step();
    restart0 = 1'b0; iv0 = 1'b0;
    chk("restart_state", 32'(st0), 32'd0);
    chk("restart_valid", 32'(ov0), 32'd0);
    chk("restart_out_held", 32'(out0), 32'd1);
    in0(2'b11, ex(1'b1, 2'd3, 1'b0));
    step();

    // async reset mid-stream
    iv0 = 1'b1; input_signal = 2'b01;
    #2 reset = 1'b1;
    #1;
    chk("async_state", 32'(st0), 32'd0);
    chk("async_out", 32'(out0), 32'd0);
    chk("async_valid", 32'(ov0), 32'd0);
    chk("async_err", 32'(err0), 32'd0);
    chk("async_dwell", 32'(dw1), 32'd0);
    iv0 = 1'b0;
    #1 reset = 1'b0;
    step();
    in0(2'b11, ex(1'b0, 2'd0, 1'b0));
    step();

    // NUM_STATES=3 instance: next_state=3 is illegal
    wr(4'b0001, 3'b111);
    iv1 = 1'b1; input_signal = 2'b01; q1.push_back(ex(1'b1, 2'd0, 1'b1));
    step();
    iv1 = 1'b0;
    repeat (3) step();
    chk("illegal_err_sticky", 32'(err1), 32'd1);
    chk("illegal_state", 32'(st1), 32'd0);
    iv1 = 1'b1; input_signal = 2'b00; q1.push_back(ex(1'b0, 2'd0, 1'b1));
    step();
    iv1 = 1'b0;
    restart1 = 1'b1;
    step();
    restart1 = 1'b0;
    chk("restart_clears_err", 32'(err1), 32'd0);
    chk("restart1_valid", 32'(ov1), 32'd0);

    // dwell counter
    restart0 = 1'b1;
    step();
    restart0 = 1'b0;
    chk("dwell_after_restart", 32'(dw0), 32'd0);
    repeat (10) step();
    chk("dwell_10", 32'(dw0), DWELL ? 32'd10 : 32'd0);
    repeat (70000) step();
    chk("dwell_saturate", 32'(dw0), DWELL ? 32'hFFFF : 32'd0);
    in0(2'b01, ex(1'b1, 2'd3, 1'b0));
    chk("dwell_state_change", 32'(dw0), 32'd0);
    chk("dwell_new_state", 32'(st0), 32'd3);
    step();
    step();
    chk("dwell_count_resumes", 32'(dw0), DWELL ? 32'd2 : 32'd0);

    repeat (3) step();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
